bin2bcd_seq: RTL and testbench

Multi-cycle binary-to-BCD converter that sequences the double-dabble datapath one shift per clock under a valid/ready handshake. It replaces the fully unrolled combinational converter wherever input width or timing makes the unrolled form too deep, such as display drivers and UART number formatters. It accepts one binary word, runs W add-3/shift iterations, and holds the packed BCD result until the consumer takes it.

---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One add-3/shift iteration per clock, valid/ready on both sides.
module bin2bcd_seq #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic           iCLK,
   input  logic           iRST,
   input  logic           iVALID,
   output logic           oREADY,
   input  logic [W-1:0]   iBIN,
   output logic           oVALID,
   input  logic           iREADY,
   output logic [4*D-1:0] oBCD,
   output logic           oBUSY
);
   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * D;

   // True when D decimal digits can hold the largest W-bit value.
   function automatic bit digits_fit();
      logic [W+3:0] m;
      m = {4'd0, {W{1'b1}}};
      for (int i = 0; i < D; i++) m = m / (W+4)'(10);
      return m == '0;
   endfunction

   localparam bit FITS = digits_fit();

   generate
      if (W < 1) begin : g_bad_w
         $error("bin2bcd_seq: W must be at least 1");
      end
      if (!FITS) begin : g_bad_d
         $error("bin2bcd_seq: D too small for W");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_HOLD
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [BW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bcd_q, bcd_d;

   logic [BW-1:0] acc_adj;
   logic [BW-1:0] acc_shl;
   logic [W-1:0]  sh_shl;

   // Digits are tested on their pre-adjust values, independently.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < D; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign acc_shl = {acc_adj[BW-2:0], sh_q[W-1]};

   generate
      if (W == 1) begin : g_sh1
         assign sh_shl = 1'b0;
      end else begin : g_shn
         assign sh_shl = {sh_q[W-2:0], 1'b0};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         S_IDLE: begin
            if (iVALID) begin
               sh_d    = iBIN;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sh_d  = sh_shl;
            acc_d = acc_shl;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               bcd_d   = acc_shl;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (iREADY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   assign oREADY = (state_q == S_IDLE);
   assign oBUSY  = (state_q == S_SHIFT);
   assign oVALID = (state_q == S_HOLD);
   assign oBCD   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq.
// Drivers queue expected results; monitors pop them on oVALID rise.
module tb_bin2bcd_seq;
   typedef struct {
      logic [15:0] bcd;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t q8[$];
   exp_t q10[$];
   exp_t q1[$];

   logic        v8, r8o, ov8, ir8, busy8;
   logic [7:0]  bin8;
   logic [11:0] bcd8;
   logic [11:0] last8 = '0;

   logic        v10, r10o, ov10, ir10, busy10;
   logic [9:0]  bin10;
   logic [15:0] bcd10;

   logic        v1, r1o, ov1, ir1, busy1;
   logic [0:0]  bin1;
   logic [3:0]  bcd1;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_seq #(.W(8), .D(3)) dut8 (
      .iCLK(clk), .iRST(rst), .iVALID(v8), .oREADY(r8o), .iBIN(bin8),
      .oVALID(ov8), .iREADY(ir8), .oBCD(bcd8), .oBUSY(busy8)
   );

   bin2bcd_seq #(.W(10), .D(4)) dut10 (
      .iCLK(clk), .iRST(rst), .iVALID(v10), .oREADY(r10o), .iBIN(bin10),
      .oVALID(ov10), .iREADY(ir10), .oBCD(bcd10), .oBUSY(busy10)
   );

   bin2bcd_seq #(.W(1), .D(1)) dut1 (
      .iCLK(clk), .iRST(rst), .iVALID(v1), .oREADY(r1o), .iBIN(bin1),
      .oVALID(ov1), .iREADY(ir1), .oBCD(bcd1), .oBUSY(busy1)
   );

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic void bad(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endfunction

   function automatic logic [15:0] ref_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic send8(input logic [7:0] v, input logic [15:0] e, output int acc);
      int n;
      n = 0;
      acc = -1;
      while (!r8o && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!r8o) begin
         bad("send8_ready_timeout");
         return;
      end
      v8 = 1'b1;
      bin8 = v;
      q8.push_back('{bcd: e, due: cyc + 1 + 8});
      acc = cyc + 1;
      @(negedge clk);
      v8 = 1'b0;
      bin8 = 8'hA5;
   endtask

   task automatic wait8();
      int n;
      n = 0;
      while (!(q8.size() == 0 && r8o) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) bad("wait8_timeout");
   endtask

   // Monitor for the W=8 instance.
   initial begin
      int   busy_n;
      logic pv;
      exp_t e;
      busy_n = 0;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_n = 0;
            pv = 1'b0;
            last8 = '0;
         end else begin
            if (busy8) begin
               busy_n++;
               chk("shift_hold8", 32'(bcd8), 32'(last8));
            end
            if (ov8 && !pv) begin
               if (q8.size() == 0) begin
                  bad("unexpected_valid8");
               end else begin
                  e = q8.pop_front();
                  chk("result8", 32'(bcd8), 32'(e.bcd));
                  chk("latency8", 32'(cyc), 32'(e.due));
                  chk("busy_cycles8", 32'(busy_n), 32'd8);
               end
               last8 = bcd8;
               busy_n = 0;
            end else if (ov8) begin
               chk("hold_stable8", 32'(bcd8), 32'(last8));
            end
            pv = ov8;
         end
      end
   end

   // Monitors for the W=10 and W=1 instances.
   initial begin
      logic pv10, pv1;
      exp_t e;
      pv10 = 1'b0;
      pv1 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ov10 && !pv10) begin
               if (q10.size() == 0) bad("unexpected_valid10");
               else begin
                  e = q10.pop_front();
                  chk("result10", 32'(bcd10), 32'(e.bcd));
                  chk("latency10", 32'(cyc), 32'(e.due));
               end
            end
            if (ov1 && !pv1) begin
               if (q1.size() == 0) bad("unexpected_valid1");
               else begin
                  e = q1.pop_front();
                  chk("result1", 32'(bcd1), 32'(e.bcd));
                  chk("latency1", 32'(cyc), 32'(e.due));
               end
            end
         end
         pv10 = ov10;
         pv1 = ov1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, n;
      v8 = 0; bin8 = 0; ir8 = 0;
      v10 = 0; bin10 = 0; ir10 = 1;
      v1 = 0; bin1 = 0; ir1 = 1;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(r8o), 32'd1);
      chk("rst_valid", 32'(ov8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_bcd", 32'(bcd8), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 255 with backpressure
      send8(8'd255, 16'h0255, a0);
      n = 0;
      while (!ov8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ov8) bad("valid255_timeout");
      repeat (5) @(negedge clk);
      chk("valid_held", 32'(ov8), 32'd1);
      chk("bcd_held", 32'(bcd8), 32'h255);
      ir8 = 1'b1;
      @(negedge clk);
      chk("handoff_valid", 32'(ov8), 32'd0);
      chk("handoff_ready", 32'(r8o), 32'd1);

      // back-to-back, iREADY high
      send8(8'd0, 16'h0000, a0);
      send8(8'd99, 16'h0099, a1);
      send8(8'd128, 16'h0128, a2);
      wait8();
      chk("spacing_0_99", 32'(a1 - a0), 32'd10);
      chk("spacing_99_128", 32'(a2 - a1), 32'd10);

      // iVALID/iBIN noise during SHIFT and HOLD
      ir8 = 1'b0;
      send8(8'd42, 16'h0042, a0);
      for (int i = 0; i < 11; i++) begin
         v8 = ~i[0];
         bin8 = 8'd7;
         @(negedge clk);
      end
      chk("hold_before_handoff", 32'(ov8), 32'd1);
      v8 = 1'b1;
      ir8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_extra_busy", 32'(busy8), 32'd0);
         chk("no_extra_ready", 32'(r8o), 32'd1);
      end

      // reset on the 4th SHIFT cycle of 200
      send8(8'd200, 16'h0200, a0);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy8), 32'd1);
      #2 rst = 1'b1;
      q8.delete();
      #1;
      chk("arst_ready", 32'(r8o), 32'd1);
      chk("arst_valid", 32'(ov8), 32'd0);
      chk("arst_busy", 32'(busy8), 32'd0);
      chk("arst_bcd", 32'(bcd8), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("idle_after_rst", 32'(r8o), 32'd1);
      chk("bcd_after_rst", 32'(bcd8), 32'd0);
      send8(8'd201, 16'h0201, a0);
      wait8();

      // all W=8 inputs
      for (int i = 0; i < 256; i++) send8(8'(i), ref_bcd(i), a0);
      wait8();

      // W=10, D=4
      @(negedge clk);
      v10 = 1'b1;
      bin10 = 10'd1023;
      q10.push_back('{bcd: 16'h1023, due: cyc + 1 + 10});
      @(negedge clk);
      v10 = 1'b0;
      bin10 = '0;
      n = 0;
      while (!(q10.size() == 0 && r10o) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) bad("wait10_timeout");

      // W=1, D=1
      for (int i = 0; i < 2; i++) begin
         n = 0;
         while (!r1o && n < 10) begin
            @(negedge clk);
            n++;
         end
         if (!r1o) bad("send1_ready_timeout");
         v1 = 1'b1;
         bin1 = i[0];
         q1.push_back('{bcd: 16'(i), due: cyc + 1 + 1});
         @(negedge clk);
         v1 = 1'b0;
      end
      n = 0;
      while (!(q1.size() == 0 && r1o) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) bad("wait1_timeout");

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
